// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite blitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    typedef logic        [15:0] color_t;      // RGB565
    typedef logic        [16:0] fb_addr_t;    // framebuffer word address
    typedef logic signed [10:0] scr_coord_t;  // signed screen coordinate

    localparam color_t KEY_COLOR = 16'hffff;  // transparent, never written

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Maps a sprite (row, col) to its ROM pixel index and framebuffer address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the inputs while stalled.
// Ports: i_row/i_col sprite position, i_spr_w width, i_origin_x/y screen origin,
//        i_flip_h mirror; o_rom_pixel, o_sx/o_sy, o_on_screen, o_fb_addr.
module blit_addr_gen
    import sprite_pkg::*;
(
    input  logic        [5:0]  i_row,
    input  logic        [5:0]  i_col,
    input  logic        [5:0]  i_spr_w,
    input  logic signed [10:0] i_origin_x,
    input  logic signed [10:0] i_origin_y,
    input  logic               i_flip_h,
    output logic        [16:0] o_rom_pixel,
    output logic signed [10:0] o_sx,
    output logic signed [10:0] o_sy,
    output logic               o_on_screen,
    output logic        [16:0] o_fb_addr
);

    localparam scr_coord_t SX_LIM = scr_coord_t'(SCREEN_W);
    localparam scr_coord_t SY_LIM = scr_coord_t'(SCREEN_H);
    localparam fb_addr_t   ROW_PITCH = fb_addr_t'(SCREEN_W);

    logic [11:0] w_row_base;
    logic [5:0]  w_col_idx;
    fb_addr_t    w_sx_ext;
    fb_addr_t    w_sy_ext;

    // 6x6 product fits exactly in 12 bits; zero-extended into the 17-bit index.
    assign w_row_base  = {6'd0, i_row} * {6'd0, i_spr_w};
    assign w_col_idx   = i_flip_h ? (i_spr_w - 6'd1 - i_col) : i_col;
    assign o_rom_pixel = {5'd0, w_row_base} + {11'd0, w_col_idx};

    // Screen position always advances left to right; flip only changes which
    // ROM column feeds it. Wraps at 11 bits like the coordinate type.
    assign o_sx = i_origin_x + $signed({5'd0, i_col});
    assign o_sy = i_origin_y + $signed({5'd0, i_row});

    assign o_on_screen = !o_sx[10] && !o_sy[10] && (o_sx < SX_LIM) && (o_sy < SY_LIM);

    // Only meaningful when on screen, where both coordinates are non-negative.
    assign w_sx_ext  = {6'd0, o_sx};
    assign w_sy_ext  = {6'd0, o_sy};
    assign o_fb_addr = w_sy_ext * ROW_PITCH + w_sx_ext;

endmodule

// File: rtl/sprite_blitter.sv
// Copies opaque, on-screen sprite ROM pixels into the RGB565 framebuffer.
// Latency: first write 2 cycles after start, 1 pixel/cycle, done at N+2.
// Backpressure: fb_valid && !fb_ready freezes counters, ROM index and output reg.
// Ports: i_clk/i_reset, draw command (i_start, i_origin_x/y, i_flip_h, i_spr_w/h),
//        ROM (o_rom_pixel, i_rom_color), framebuffer (o_fb_addr, o_fb_data,
//        o_fb_valid, i_fb_ready), status (o_busy, o_done).
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic signed [10:0] i_origin_x,
    input  logic signed [10:0] i_origin_y,
    input  logic               i_flip_h,
    input  logic        [5:0]  i_spr_w,
    input  logic        [5:0]  i_spr_h,
    output logic        [16:0] o_rom_pixel,
    input  logic        [15:0] i_rom_color,
    output logic        [16:0] o_fb_addr,
    output logic        [15:0] o_fb_data,
    output logic               o_fb_valid,
    input  logic               i_fb_ready,
    output logic               o_busy,
    output logic               o_done
);

    blit_state_t r_state;
    logic [5:0]  r_row, r_col, r_spr_w, r_spr_h;
    scr_coord_t  r_origin_x, r_origin_y;
    logic        r_flip_h;
    fb_addr_t    r_fb_addr;
    color_t      r_fb_data;
    logic        r_fb_valid, r_busy, r_done;

    scr_coord_t  w_sx, w_sy;
    logic        w_on_screen, w_write, w_stall, w_last_col, w_last_row;
    fb_addr_t    w_fb_addr;
    logic        w_unused;

    blit_addr_gen u_addr_gen (
        .i_row       (r_row),
        .i_col       (r_col),
        .i_spr_w     (r_spr_w),
        .i_origin_x  (r_origin_x),
        .i_origin_y  (r_origin_y),
        .i_flip_h    (r_flip_h),
        .o_rom_pixel (o_rom_pixel),
        .o_sx        (w_sx),
        .o_sy        (w_sy),
        .o_on_screen (w_on_screen),
        .o_fb_addr   (w_fb_addr)
    );

    // Coordinates are folded into o_on_screen / o_fb_addr already.
    assign w_unused = ^{w_sx, w_sy};

    assign w_stall    = r_fb_valid && !i_fb_ready;
    assign w_write    = (i_rom_color != KEY_COLOR) && w_on_screen;
    assign w_last_col = (r_col == r_spr_w - 6'd1);
    assign w_last_row = (r_row == r_spr_h - 6'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_spr_w    <= '0;
            r_spr_h    <= '0;
            r_origin_x <= '0;
            r_origin_y <= '0;
            r_flip_h   <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
            r_fb_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_origin_x <= i_origin_x;
                        r_origin_y <= i_origin_y;
                        r_flip_h   <= i_flip_h;
                        r_spr_w    <= i_spr_w;
                        r_spr_h    <= i_spr_h;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_busy     <= 1'b1;
                        // Empty sprite skips the scan entirely.
                        r_state    <= (i_spr_w == 6'd0 || i_spr_h == 6'd0) ? ST_DRAIN : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_stall) begin
                        // Output register either takes this pixel or goes idle;
                        // skipped pixels leave the old addr/data in place.
                        r_fb_valid <= w_write;
                        if (w_write) begin
                            r_fb_addr <= w_fb_addr;
                            r_fb_data <= i_rom_color;
                        end
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_row   <= '0;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_row <= r_row + 6'd1;
                            end
                        end else begin
                            r_col <= r_col + 6'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish only once the last write has been taken.
                    if (!w_stall) begin
                        r_fb_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_fb_addr  = r_fb_addr;
    assign o_fb_data  = r_fb_data;
    assign o_fb_valid = r_fb_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

    logic               clk = 1'b0;
    logic               reset, start, flip_h, fb_ready;
    logic signed [10:0] origin_x, origin_y;
    logic        [5:0]  spr_w, spr_h;
    logic        [16:0] rom_pixel, fb_addr;
    logic        [15:0] rom_color, fb_data;
    logic               fb_valid, busy, done;
    logic        [15:0] rom_mem [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rom_color = rom_mem[rom_pixel[5:0]];

    sprite_blitter dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_origin_x  (origin_x),
        .i_origin_y  (origin_y),
        .i_flip_h    (flip_h),
        .i_spr_w     (spr_w),
        .i_spr_h     (spr_h),
        .o_rom_pixel (rom_pixel),
        .i_rom_color (rom_color),
        .o_fb_addr   (fb_addr),
        .o_fb_data   (fb_data),
        .o_fb_valid  (fb_valid),
        .i_fb_ready  (fb_ready),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Capture of one command: accepted writes and per-cycle output snapshots.
    int          wr_cnt, done_cyc;
    logic        busy_at_done;
    logic [16:0] wr_addr [16];
    logic [15:0] wr_data [16];
    int          wr_cyc  [16];
    logic [16:0] rp_log   [64];
    logic [16:0] addr_log [64];
    logic [15:0] data_log [64];

    // Cycle 0 is the cycle whose closing edge accepts start; cycle k is
    // sampled on the falling edge k half-periods after that edge.
    task automatic run_cmd(input int ox, input int oy, input logic flip,
                           input int w, input int h, input int stall);
        int stall_left;
        stall_left   = stall;
        wr_cnt       = 0;
        done_cyc     = -1;
        busy_at_done = 1'b1;
        @(negedge clk);
        origin_x = 11'(ox);
        origin_y = 11'(oy);
        flip_h   = flip;
        spr_w    = 6'(w);
        spr_h    = 6'(h);
        fb_ready = 1'b1;
        start    = 1'b1;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            start       = 1'b0;
            rp_log[k]   = rom_pixel;
            addr_log[k] = fb_addr;
            data_log[k] = fb_data;
            if (fb_valid && stall_left > 0) begin
                fb_ready   = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                fb_ready = 1'b1;
            end
            if (fb_valid && fb_ready) begin
                if (wr_cnt < 16) begin
                    wr_addr[wr_cnt] = fb_addr;
                    wr_data[wr_cnt] = fb_data;
                    wr_cyc[wr_cnt]  = k;
                end
                wr_cnt = wr_cnt + 1;
            end
            if (done) begin
                done_cyc     = k;
                busy_at_done = busy;
                break;
            end
        end
        fb_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rom_pixel !== 17'd0) begin n_fail++; $display("FAIL reset_rom_pixel: got %0d want 0", rom_pixel); end
        n_checks++; if (fb_addr !== 17'd0)   begin n_fail++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
        n_checks++; if (fb_data !== 16'd0)   begin n_fail++; $display("FAIL reset_fb_data: got %h want 0", fb_data); end
        n_checks++; if (fb_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_fb_valid: got %b want 0", fb_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_basic_2x2();
        int exp_addr [4] = '{0, 1, 320, 321};
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'h1000 + 16'(i);
        run_cmd(0, 0, 1'b0, 2, 2, 0);
        n_checks++; if (wr_cnt !== 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", wr_cnt); end
        for (int i = 0; i < 4 && i < wr_cnt; i++) begin
            n_checks++; if (wr_addr[i] !== 17'(exp_addr[i])) begin n_fail++; $display("FAIL basic_addr%0d: got %0d want %0d", i, wr_addr[i], exp_addr[i]); end
            n_checks++; if (wr_data[i] !== 16'h1000 + 16'(i)) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, wr_data[i], 16'h1000 + 16'(i)); end
            n_checks++; if (wr_cyc[i] !== i + 2) begin n_fail++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, wr_cyc[i], i + 2); end
        end
        n_checks++; if (done_cyc !== 6) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 6", done_cyc); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_key_color();
        rom_mem[0] = 16'h2082;
        rom_mem[1] = 16'hffff;
        rom_mem[2] = 16'h08b2;
        run_cmd(10, 5, 1'b0, 3, 1, 0);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL key_count: got %0d want 2", wr_cnt); end
        n_checks++; if (wr_addr[0] !== 17'd1610 || wr_data[0] !== 16'h2082) begin n_fail++; $display("FAIL key_write0: got %0d/%h want 1610/2082", wr_addr[0], wr_data[0]); end
        n_checks++; if (wr_addr[1] !== 17'd1612 || wr_data[1] !== 16'h08b2) begin n_fail++; $display("FAIL key_write1: got %0d/%h want 1612/08b2", wr_addr[1], wr_data[1]); end
        n_checks++; if (done_cyc !== 5) begin n_fail++; $display("FAIL key_done_cycle: got %0d want 5", done_cyc); end
    endtask

    task automatic test_clipping();
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0040 + 16'(i);
        run_cmd(318, 0, 1'b0, 4, 1, 0);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL clip_right_count: got %0d want 2", wr_cnt); end
        n_checks++; if (wr_addr[0] !== 17'd318 || wr_addr[1] !== 17'd319) begin n_fail++; $display("FAIL clip_right_addr: got %0d,%0d want 318,319", wr_addr[0], wr_addr[1]); end
        n_checks++; if (done_cyc !== 6) begin n_fail++; $display("FAIL clip_right_done: got %0d want 6", done_cyc); end
        run_cmd(-2, 239, 1'b0, 4, 1, 0);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL clip_left_count: got %0d want 2", wr_cnt); end
        n_checks++; if (wr_addr[0] !== 17'd76480 || wr_addr[1] !== 17'd76481) begin n_fail++; $display("FAIL clip_left_addr: got %0d,%0d want 76480,76481", wr_addr[0], wr_addr[1]); end
        n_checks++; if (wr_data[0] !== 16'h0042 || wr_data[1] !== 16'h0043) begin n_fail++; $display("FAIL clip_left_data: got %h,%h want 0042,0043", wr_data[0], wr_data[1]); end
    endtask

    task automatic test_flip();
        rom_mem[0] = 16'h00a0;
        rom_mem[1] = 16'h00a1;
        rom_mem[2] = 16'h00a2;
        run_cmd(20, 10, 1'b1, 3, 1, 0);
        n_checks++; if (rp_log[1] !== 17'd2 || rp_log[2] !== 17'd1 || rp_log[3] !== 17'd0) begin n_fail++; $display("FAIL flip_rom_seq: got %0d,%0d,%0d want 2,1,0", rp_log[1], rp_log[2], rp_log[3]); end
        n_checks++; if (wr_cnt !== 3) begin n_fail++; $display("FAIL flip_count: got %0d want 3", wr_cnt); end
        for (int i = 0; i < 3 && i < wr_cnt; i++) begin
            n_checks++; if (wr_addr[i] !== 17'(3220 + i) || wr_data[i] !== 16'h00a2 - 16'(i)) begin n_fail++; $display("FAIL flip_write%0d: got %0d/%h want %0d/%h", i, wr_addr[i], wr_data[i], 3220 + i, 16'h00a2 - 16'(i)); end
        end
    endtask

    task automatic test_zero_size();
        run_cmd(0, 0, 1'b0, 0, 3, 0);
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL zero_count: got %0d want 0", wr_cnt); end
        n_checks++; if (done_cyc !== 2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc); end
    endtask

    task automatic test_backpressure();
        rom_mem[0] = 16'h5a5a;
        rom_mem[1] = 16'h0f0f;
        run_cmd(5, 5, 1'b0, 2, 1, 3);
        for (int k = 2; k <= 5; k++) begin
            n_checks++; if (addr_log[k] !== 17'd1605 || data_log[k] !== 16'h5a5a || rp_log[k] !== 17'd1) begin n_fail++; $display("FAIL bp_hold_cycle%0d: got addr %0d data %h rom %0d want 1605 5a5a 1", k, addr_log[k], data_log[k], rp_log[k]); end
        end
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", wr_cnt); end
        n_checks++; if (wr_cyc[0] !== 5 || wr_cyc[1] !== 6) begin n_fail++; $display("FAIL bp_write_cycles: got %0d,%0d want 5,6", wr_cyc[0], wr_cyc[1]); end
        n_checks++; if (wr_addr[1] !== 17'd1606 || wr_data[1] !== 16'h0f0f) begin n_fail++; $display("FAIL bp_write1: got %0d/%h want 1606/0f0f", wr_addr[1], wr_data[1]); end
        n_checks++; if (done_cyc !== 7) begin n_fail++; $display("FAIL bp_done_cycle: got %0d want 7", done_cyc); end
    endtask

    task automatic test_reset_mid_scan();
        int seen_done;
        int seen_valid;
        seen_done  = 0;
        seen_valid = 0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0400 + 16'(i);
        @(negedge clk);
        origin_x = 11'sd0;
        origin_y = 11'sd0;
        flip_h   = 1'b0;
        spr_w    = 6'd4;
        spr_h    = 6'd1;
        fb_ready = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (fb_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pending: got valid %b busy %b want 1 1", fb_valid, busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (fb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fb_valid: got %b want 0", fb_valid); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
        reset    = 1'b0;
        fb_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
            if (fb_valid) seen_valid++;
        end
        n_checks++; if (seen_done !== 0)  begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen_done); end
        n_checks++; if (seen_valid !== 0) begin n_fail++; $display("FAIL rst_mid_no_write: got %0d writes want 0", seen_valid); end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        flip_h   = 1'b0;
        fb_ready = 1'b1;
        origin_x = '0;
        origin_y = '0;
        spr_w    = '0;
        spr_h    = '0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0000;
        test_reset();
        test_basic_2x2();
        test_key_color();
        test_clipping();
        test_flip();
        test_zero_size();
        test_backpressure();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Reads a sprite ROM pixel by pixel and writes its opaque, on-screen pixels into the RGB565 framebuffer at a given screen origin. It sits between the game/overworld control logic, which issues one draw command per sprite, and the framebuffer write port. It drives the sprite ROM's pixel index and consumes its color and dimensions, so any sprite ROM module plugs straight in.

## Interface
- SCREEN_W, 320, framebuffer width in pixels.
- SCREEN_H, 240, framebuffer height in pixels.
- KEY_COLOR, 16'hffff, transparent color; pixels of this value are never written.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  draw command strobe; accepted only in IDLE.
- origin_x  in  11  signed screen X of sprite column 0, latched on accepted start.
- origin_y  in  11  signed screen Y of sprite row 0, latched on accepted start.
- flip_h  in  1  mirror horizontally, latched on accepted start.
- spr_w  in  6  sprite width from ROM, latched on accepted start.
- spr_h  in  6  sprite height from ROM, latched on accepted start.
- rom_pixel  out  17  ROM pixel index.
- rom_color  in  16  ROM color, combinational from rom_pixel.
- fb_addr  out  17  framebuffer word address.
- fb_data  out  16  framebuffer write data.
- fb_valid  out  1  write request.
- fb_ready  in  1  framebuffer accepts the write when fb_valid && fb_ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE to SCAN on start. Latches the command and clears row r and column c to 0.
- Zero-size command: start with spr_w==0 or spr_h==0 goes IDLE to DRAIN directly. No ROM read, no write.
- SCAN presents rom_pixel = r*spr_w + (flip_h ? spr_w-1-c : c).
  - Width rule: product computed at 12 bits, zero-extended to 17.
- Screen coordinates: sx = origin_x + c, sy = origin_y + r, both signed 11-bit.
- A pixel is written only if rom_color != KEY_COLOR and 0 <= sx < SCREEN_W and 0 <= sy < SCREEN_H.
  - Written pixels load the output register: fb_addr = sy*SCREEN_W + sx, fb_data = rom_color, fb_valid = 1.
  - Skipped pixels consume their cycle and produce no fb_valid.
- Counter advance: c increments. At c==spr_w-1, c returns to 0 and r increments.
- After pixel (spr_h-1, spr_w-1) is processed, SCAN goes to DRAIN.
- DRAIN waits until no write is pending, then pulses done, drops busy and returns to IDLE.
- Backpressure: while fb_valid && !fb_ready, the counters, rom_pixel and the output register all hold.
- start while busy is ignored.
- Reset mid-operation: the next cycle is IDLE with fb_valid=0, busy=0 and no done pulse. A pending write is dropped.

## Timing
- Reset values: rom_pixel=0, fb_addr=0, fb_data=0, fb_valid=0, busy=0, done=0.
- start accepted in cycle 0. busy=1 and the first rom_pixel appear in cycle 1.
- The first fb_valid for pixel 0 appears in cycle 2. ROM-to-write latency is 1 cycle.
- Throughput is 1 pixel per cycle with fb_ready held high.
- For N = spr_w*spr_h pixels with no stalls, done is high in cycle N+2 and busy is low in that same cycle.
- Every cycle of fb_ready low with fb_valid high adds exactly one cycle.
- The zero-size command gives done in cycle 2.
- Writes issue in raster order: row-major, with sprite columns left to right.

## Structure
- Shared package sprite_pkg holds:
  - SCREEN_W, SCREEN_H, KEY_COLOR.
  - typedef color_t (16-bit RGB565).
  - typedef fb_addr_t (17-bit).
  - typedef scr_coord_t (signed 11-bit).
- Sub-module blit_addr_gen takes r, c, origin and flip.
- It is purely combinational and produces rom_pixel, sx, sy, the on-screen flag and fb_addr.
- The FSM, counters and output register stay in sprite_blitter.

## Test plan
- 2x2 all-opaque sprite at (0,0), fb_ready=1: writes to fb_addr 0, 1, 320, 321 in cycles 2-5, done in cycle 6.
- 3x1 sprite with colors {16'h2082, KEY_COLOR, 16'h8b2} at (10,5): exactly two writes, to 1610 and 1612; done in cycle 5.
- 4x1 opaque sprite at (318,0): writes only 318 and 319.
- 4x1 opaque sprite at (-2,239): writes only 76480 and 76481.
- 3x1 sprite with flip_h=1: rom_pixel sequence is 2, 1, 0; data lands at origin+0 through origin+2 in that order.
- 2x1 opaque sprite with fb_ready low for 3 cycles on the first write: fb_addr and fb_data stay stable, rom_pixel holds, done is delayed 3 cycles. Then reset mid-SCAN: the next cycle shows fb_valid=0 and busy=0, and no done pulse is ever produced.
